mdu_unit: RTL and testbench

- Multi-cycle multiply/divide unit in the E stage, alongside the single-cycle ALU.
- The ALU returns its result in the same cycle. This block accepts a start pulse, holds busy for a fixed latency, then commits its results into the architectural HI/LO registers.
- The hazard unit stalls the D stage on busy, or on start together with any MDU-class instruction.
- Also serves MTHI/MTLO writes and MFHI/MFLO reads.

---
 rtl/mdu_unit_pkg.sv | 25 ++
 rtl/mdu_unit.sv | 125 ++++++++++++
 tb/tb_mdu_unit.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mdu_unit_pkg.sv
// Shared definitions for the multiply/divide unit: MDUOp encodings (also used
// by the controller), default latencies and FSM state encodings.
package mdu_unit_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } mdu_op_e;

  localparam int unsigned MULT_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu_unit.sv
// Multi-cycle MULT/DIV unit: the result is computed at launch, held in temp
// registers, and committed to HI/LO when the latency counter expires.
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] rdata
);

  localparam logic [3:0] MULT_LAT_C = 4'(MULT_LAT);
  localparam logic [3:0] DIV_LAT_C  = 4'(DIV_LAT);

  mdu_op_e    op;
  mdu_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] thi_q, thi_d, tlo_q, tlo_d;

  logic [63:0] prod_s, prod_u;
  logic        div_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

  assign op = mdu_op_e'(MDUOp);

  // Sign-extending to 64 bits makes an unsigned multiply yield the signed product.
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed division via magnitudes so 0x80000000 / -1 wraps cleanly.
  always_comb begin
    div_signed = (op == OP_DIV);
    a_neg      = div_signed & A[31];
    b_neg      = div_signed & B[31];
    a_mag      = a_neg ? -A : A;
    b_mag      = (B == 32'd0) ? 32'd1 : (b_neg ? -B : B);
    q_mag      = a_mag / b_mag;
    r_mag      = a_mag % b_mag;
    quot       = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem        = a_neg ? -r_mag : r_mag;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    thi_d   = thi_q;
    tlo_d   = tlo_q;
    case (state_q)
      ST_IDLE: begin
        if (start && (op == OP_MULT || op == OP_MULTU || op == OP_DIV || op == OP_DIVU)) begin
          state_d = ST_RUN;
          busy_d  = 1'b1;
          if (op == OP_MULT || op == OP_MULTU) begin
            cnt_d = MULT_LAT_C;
            {thi_d, tlo_d} = (op == OP_MULT) ? prod_s : prod_u;
          end else begin
            cnt_d = DIV_LAT_C;
            // Divide by zero commits the current HI/LO unchanged.
            if (B == 32'd0) begin
              thi_d = hi_q;
              tlo_d = lo_q;
            end else begin
              thi_d = rem;
              tlo_d = quot;
            end
          end
        end else if (op == OP_MTHI) begin
          hi_d = A;
        end else if (op == OP_MTLO) begin
          lo_d = A;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          hi_d    = thi_q;
          lo_d    = tlo_q;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      thi_q   <= 32'd0;
      tlo_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      thi_q   <= thi_d;
      tlo_q   <= tlo_d;
    end
  end

  assign busy  = busy_q;
  assign HI    = hi_q;
  assign LO    = lo_q;
  assign rdata = (op == OP_MFHI) ? hi_q : (op == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed, table-driven bench for mdu_unit: launch/latency/commit per vector,
// plus hand-written sequences for ignored starts, async reset and MTLO/MFLO.
module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  MDUOp = 4'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        busy;
  logic [31:0] HI, LO, rdata;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  mdu_unit #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .start(start), .MDUOp(MDUOp),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO), .rdata(rdata)
  );

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] v);
    @(negedge clk);
    MDUOp = op; A = v;
    @(negedge clk);
    MDUOp = 4'd0; A = 32'd0;
  endtask

  task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; MDUOp = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0; MDUOp = 4'd0; A = 32'd0; B = 32'd0;
  endtask

  initial begin
    int n;
    logic hold_ok;

    vecs[0] = '{"mult_neg1x2",   4'd1, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    vecs[1] = '{"multu_ffx2",    4'd2, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2] = '{"divu_7_2",      4'd4, 32'd7, 32'd2, 32'd0, 32'd0, 32'd1, 32'd3, 10};
    vecs[3] = '{"div_m7_2",      4'd3, 32'hFFFFFFF9, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[4] = '{"div_by0",       4'd3, 32'd5, 32'd0, 32'h11, 32'h22, 32'h11, 32'h22, 10};
    vecs[5] = '{"div_ovf",       4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h5, 32'h6, 32'd0, 32'h80000000, 10};
    vecs[6] = '{"divu_by0",      4'd4, 32'd9, 32'd0, 32'h33, 32'h44, 32'h33, 32'h44, 10};
    vecs[7] = '{"mult_maxpos",   4'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'd0, 32'd0, 32'h3FFFFFFF, 32'h00000001, 5};
    vecs[8] = '{"mult_m3x5",     4'd1, 32'hFFFFFFFD, 32'd5, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF1, 5};
    vecs[9] = '{"div_7_m2",      4'd3, 32'd7, 32'hFFFFFFFE, 32'd0, 32'd0, 32'd1, 32'hFFFFFFFD, 10};

    #12;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      mt(4'd5, vecs[i].pre_hi);
      mt(4'd6, vecs[i].pre_lo);
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      n = 0;
      hold_ok = 1'b1;
      while (busy && n < 40) begin
        if (HI !== vecs[i].pre_hi || LO !== vecs[i].pre_lo) hold_ok = 1'b0;
        n++;
        @(negedge clk);
      end
      chk({vecs[i].name, "_lat"}, n, vecs[i].lat);
      chk({vecs[i].name, "_hold"}, {31'd0, hold_ok}, 32'd1);
      chk({vecs[i].name, "_hi"}, HI, vecs[i].exp_hi);
      chk({vecs[i].name, "_lo"}, LO, vecs[i].exp_lo);
      MDUOp = 4'd7;
      #1 chk({vecs[i].name, "_mfhi"}, rdata, vecs[i].exp_hi);
      MDUOp = 4'd8;
      #1 chk({vecs[i].name, "_mflo"}, rdata, vecs[i].exp_lo);
      MDUOp = 4'd0;
      $display("vec %0d %s: lat=%0d HI=0x%08h LO=0x%08h", i, vecs[i].name, n, HI, LO);
    end

    // Back-to-back: launch in the very first non-busy cycle after a completion.
    launch(4'd2, 32'd3, 32'd4);
    n = 0;
    while (busy && n < 40) begin n++; @(negedge clk); end
    start = 1'b1; MDUOp = 4'd2; A = 32'd6; B = 32'd7;
    @(negedge clk);
    start = 1'b0; MDUOp = 4'd0;
    chk("b2b_first_lo", LO, 32'd12);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    n = 1;
    while (busy && n < 40) begin n++; @(negedge clk); end
    chk("b2b_lat", n - 1, 32'd5);
    chk("b2b_second_lo", LO, 32'd42);
    $display("back-to-back: LO=0x%08h", LO);

    // Start with a non-launch op and with an undefined op: nothing happens.
    @(negedge clk);
    start = 1'b1; MDUOp = 4'd7;
    @(negedge clk);
    MDUOp = 4'd9;
    #1 chk("undef_rdata", rdata, 32'd0);
    @(negedge clk);
    start = 1'b0; MDUOp = 4'd0;
    chk("bad_start_busy", {31'd0, busy}, 32'd0);
    chk("bad_start_lo", LO, 32'd42);
    $display("ignored starts: busy=%0b LO=0x%08h", busy, LO);

    // Second start while busy is ignored; the DIV commits on schedule.
    launch(4'd4, 32'd100, 32'd7);
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (n == 3) begin start = 1'b1; MDUOp = 4'd1; A = 32'd2; B = 32'd3; end
      else begin start = 1'b0; MDUOp = 4'd0; end
      @(negedge clk);
    end
    start = 1'b0; MDUOp = 4'd0;
    chk("busy_start_lat", n, 32'd10);
    chk("busy_start_hi", HI, 32'd2);
    chk("busy_start_lo", LO, 32'd14);
    @(negedge clk);
    @(negedge clk);
    chk("busy_start_idle", {31'd0, busy}, 32'd0);
    $display("start while busy: lat=%0d HI=0x%08h LO=0x%08h", n, HI, LO);

    // Asynchronous reset mid-RUN, asserted and released between clock edges.
    launch(4'd1, 32'd5, 32'd5);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", HI, 32'd0);
    chk("arst_lo", LO, 32'd0);
    #4 reset = 1'b1;
    hold_ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) hold_ok = 1'b0;
    end
    chk("arst_no_commit", {31'd0, hold_ok}, 32'd1);
    $display("async reset: busy=%0b HI=0x%08h LO=0x%08h", busy, HI, LO);

    mt(4'd6, 32'h1234);
    chk("mtlo_lo", LO, 32'h1234);
    MDUOp = 4'd8;
    #1 chk("mflo_rdata", rdata, 32'h1234);
    MDUOp = 4'd0;
    $display("mtlo/mflo: LO=0x%08h", LO);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
